// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared RAM command codes, arbiter state type and command helper
package mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    // 2'b11 is not a legal command and is issued to the RAM as MNONE.
    function automatic logic [1:0] legal_cmd(input logic [1:0] cmd);
        return (cmd == MREAD || cmd == MWRITE) ? cmd : MNONE;
    endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// rtl/mem_rd_tag_pipe.sv - DEPTH-deep {valid,id} shift register tracking in-flight RAM reads
module mem_rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_id,
    output logic o_valid,
    output logic o_id
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_id    <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port RAM arbiter with bounded hold and tagged read return
// Optional MEM_ARB_RR_EN: round-robin tie break from IDLE instead of fixed m0 priority.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [HOLD_W-1:0] r_hold;
    logic              w_tie_m1;
    logic              w_tag_valid;
    logic              w_tag_id;
    logic              w_rv0;
    logic              w_rv1;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

`ifdef MEM_ARB_RR_EN
    logic r_last_owner;

    assign w_tie_m1 = ~r_last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= 1'b1;
        end else if (w_next != r_state && w_next == ARB_OWN0) begin
            r_last_owner <= 1'b0;
        end else if (w_next != r_state && w_next == ARB_OWN1) begin
            r_last_owner <= 1'b1;
        end
    end
`else
    assign w_tie_m1 = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = w_tie_m1 ? ARB_OWN1 : ARB_OWN0;
                end else if (m0_req) begin
                    w_next = ARB_OWN0;
                end else if (m1_req) begin
                    w_next = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!m0_req) begin
                    w_next = m1_req ? ARB_OWN1 : ARB_IDLE;
                end else if (m1_req && r_hold == HOLD_LAST) begin
                    w_next = ARB_OWN1;
                end
            end
            ARB_OWN1: begin
                if (!m1_req) begin
                    w_next = m0_req ? ARB_OWN0 : ARB_IDLE;
                end else if (m0_req && r_hold == HOLD_LAST) begin
                    w_next = ARB_OWN0;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_hold <= '0;
            end else if (r_state != ARB_IDLE && r_hold != HOLD_LAST) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign m0_gnt = (r_state == ARB_OWN0);
    assign m1_gnt = (r_state == ARB_OWN1);

    always_comb begin
        mem_cmd   = MNONE;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ARB_OWN0: begin
                mem_cmd   = legal_cmd(m0_cmd);
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
            end
            ARB_OWN1: begin
                mem_cmd   = legal_cmd(m1_cmd);
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    // Tags follow the read, not the current owner, so data returns correctly across switches.
    mem_rd_tag_pipe #(
        .DEPTH(RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mem_cmd == MREAD),
        .i_id    (r_state == ARB_OWN1),
        .o_valid (w_tag_valid),
        .o_id    (w_tag_id)
    );

    assign w_rv0 = w_tag_valid & ~w_tag_id & ~rst;
    assign w_rv1 = w_tag_valid &  w_tag_id & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_rv0) r_m0_rdata <= mem_rdata;
            if (w_rv1) r_m1_rdata <= mem_rdata;
        end
    end

    assign m0_rvalid = w_rv0;
    assign m1_rvalid = w_rv1;
    assign m0_rdata  = w_rv0 ? mem_rdata : r_m0_rdata;
    assign m1_rdata  = w_rv1 ? mem_rdata : r_m1_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with RAM model and ownership model
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int RD_LAT = 2;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic m0_req, m1_req;
    logic [1:0] m0_cmd, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0] mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM with RD_LAT read latency; non-read cycles return a filler pattern.
    logic [DW-1:0] ram [512];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_cmd == MREAD) ? ram[mem_addr] : 16'hA5A5;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index, cycles owned, pending read returns, shadow memory.
    typedef struct { int due; int id; logic [DW-1:0] d; } rd_t;
    rd_t pend[$];
    int mo = -1;
    int mheld = 0;
    bit mlast = 1'b1;
    bit started = 1'b0;
    int cyc_n = 0;
    logic [DW-1:0] mrd [2];
    logic [DW-1:0] mmem [512];

    function automatic bit get_req(input int id);
        return (id == 0) ? m0_req : m1_req;
    endfunction
    function automatic logic [1:0] get_cmd(input int id);
        return (id == 0) ? m0_cmd : m1_cmd;
    endfunction
    function automatic logic [AW-1:0] get_addr(input int id);
        return (id == 0) ? m0_addr : m1_addr;
    endfunction
    function automatic logic [DW-1:0] get_wdata(input int id);
        return (id == 0) ? m0_wdata : m1_wdata;
    endfunction
    function automatic logic [1:0] exp_cmd();
        logic [1:0] c;
        if (mo < 0) return MNONE;
        c = get_cmd(mo);
        return (c == MREAD || c == MWRITE) ? c : MNONE;
    endfunction
    function automatic int tie_winner();
`ifdef MEM_ARB_RR_EN
        return (mlast == 1'b1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin : model_step
        logic [1:0] c;
        int nxt;
        int oth;
        if (rst) begin
            mo = -1; mheld = 0; mlast = 1'b1; started = 1'b1;
            pend.delete();
            mrd[0] = '0; mrd[1] = '0;
        end else if (started) begin
            while (pend.size() > 0 && pend[0].due <= cyc_n) begin
                mrd[pend[0].id] = pend[0].d;
                void'(pend.pop_front());
            end
            c = exp_cmd();
            if (c == MWRITE) mmem[get_addr(mo)] = get_wdata(mo);
            else if (c == MREAD) pend.push_back('{cyc_n + RD_LAT, mo, mmem[get_addr(mo)]});
            nxt = mo;
            if (mo < 0) begin
                if (m0_req && m1_req) nxt = tie_winner();
                else if (m0_req) nxt = 0;
                else if (m1_req) nxt = 1;
            end else begin
                oth = 1 - mo;
                if (!get_req(mo)) nxt = get_req(oth) ? oth : -1;
                else if (get_req(oth) && mheld + 1 >= MAX_HOLD) nxt = oth;
            end
            if (nxt != mo) begin
                mheld = 0;
                if (nxt >= 0) mlast = nxt[0];
            end else if (mo >= 0) begin
                mheld++;
            end
            mo = nxt;
        end
        cyc_n++;
    end

    always @(negedge clk) begin : model_cmp
        logic ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        if (started) begin
            ev0 = 1'b0; ev1 = 1'b0; ed0 = mrd[0]; ed1 = mrd[1];
            if (!rst) begin
                foreach (pend[i]) begin
                    if (pend[i].due == cyc_n) begin
                        if (pend[i].id == 0) begin ev0 = 1'b1; ed0 = pend[i].d; end
                        else begin ev1 = 1'b1; ed1 = pend[i].d; end
                    end
                end
            end
            chk("m0_gnt", 32'(m0_gnt), 32'(mo == 0));
            chk("m1_gnt", 32'(m1_gnt), 32'(mo == 1));
            chk("mem_cmd", 32'(mem_cmd), 32'(exp_cmd()));
            chk("mem_addr", 32'(mem_addr), (mo < 0) ? 32'd0 : 32'(get_addr(mo)));
            chk("mem_wdata", 32'(mem_wdata), (mo < 0) ? 32'd0 : 32'(get_wdata(mo)));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
            chk("m0_rdata", 32'(m0_rdata), 32'(ed0));
            chk("m1_rdata", 32'(m1_rdata), 32'(ed1));
        end
    end

    int rv0_cnt = 0;
    int rv1_cnt = 0;
    always @(negedge clk) begin
        if (m0_rvalid === 1'b1) rv0_cnt++;
        if (m1_rvalid === 1'b1) rv1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int id, input logic req, input logic [1:0] cmd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (id == 0) begin m0_req = req; m0_cmd = cmd; m0_addr = addr; m0_wdata = wd; end
        else begin m1_req = req; m1_cmd = cmd; m1_addr = addr; m1_wdata = wd; end
    endtask

    function automatic logic gnt_of(input int id);
        return (id == 0) ? m0_gnt : m1_gnt;
    endfunction

    task automatic run_tie(input int win, input int tag);
        int los;
        los = 1 - win;
        drive(0, 1'b1, MNONE, '0, '0);
        drive(1, 1'b1, MNONE, '0, '0);
        step(1);
        chk("tie_win_gnt", 32'(gnt_of(win)), 32'd1);
        chk("tie_lose_gnt", 32'(gnt_of(los)), 32'd0);
        drive(win, 1'b1, MWRITE, AW'(32 + tag), DW'(16'hC000 + tag));
        step(1);
        drive(win, 1'b1, MREAD, AW'(32 + tag), '0);
        step(1);
        drive(win, 1'b1, MWRITE, AW'(33 + tag), DW'(16'hD000 + tag));
        step(1);
        drive(win, 1'b0, MNONE, '0, '0);
        chk("tie_win_still_gnt", 32'(gnt_of(win)), 32'd1);
        step(1);
        chk("handover_no_bubble", 32'(gnt_of(los)), 32'd1);
        drive(los, 1'b1, 2'b11, 9'h030, 16'h7777);
        step(1);
        drive(los, 1'b1, MREAD, AW'(32 + tag), '0);
        step(1);
        drive(los, 1'b0, MNONE, '0, '0);
        step(4);
    endtask

    initial begin : stim
        int k;
        int c0, c1;
        int w1, w2;
        for (int i = 0; i < 512; i++) begin
            ram[i] = DW'(i * 3 + 7);
            mmem[i] = DW'(i * 3 + 7);
        end
        ram[5] = 16'hBEEF;
        mmem[5] = 16'hBEEF;
`ifdef MEM_ARB_RR_EN
        w1 = 1; w2 = 1;
`else
        w1 = 0; w2 = 0;
`endif
        rst = 1'b1;
        drive(0, 1'b1, MNONE, '0, '0);
        drive(1, 1'b1, MNONE, '0, '0);

        // Reset with both requests held
        step(2);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
        rst = 1'b0;
        step(1);
        chk("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("post_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        drive(0, 1'b0, MNONE, '0, '0);
        drive(1, 1'b0, MNONE, '0, '0);
        step(2);

        // m0-only read of RAM[5]
        c1 = rv1_cnt;
        drive(0, 1'b1, MNONE, '0, '0);
        step(1);
        chk("rd_gnt", 32'(m0_gnt), 32'd1);
        drive(0, 1'b1, MREAD, 9'h005, '0);
        step(1);
        drive(0, 1'b0, MNONE, '0, '0);
        step(1);
        chk("rd_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_rdata", 32'(m0_rdata), 32'h0000BEEF);
        step(2);
        chk("rd_rvalid_pulse", 32'(m0_rvalid), 32'd0);
        chk("rd_rdata_hold", 32'(m0_rdata), 32'h0000BEEF);
        chk("rd_m1_quiet", 32'(rv1_cnt - c1), 32'd0);

        // Two ties from IDLE
        run_tie(w1, 0);
        run_tie(w2, 4);

        // Starvation bound: m0 reads every cycle, m1 waits with a write pending
        drive(0, 1'b1, MREAD, 9'h040, '0);
        step(1);
        drive(1, 1'b1, MWRITE, 9'h041, 16'hFFFF);
        k = 0;
        for (int i = 0; i < 20 && m0_gnt === 1'b1; i++) begin
            k++;
            m0_addr = m0_addr + 1'b1;
            step(1);
        end
        chk("starve_hold_cycles", 32'(k), 32'd8);
        chk("starve_m1_gnt", 32'(m1_gnt), 32'd1);
        drive(1, 1'b0, MNONE, '0, '0);
        step(2);
        chk("starve_m0_regains", 32'(m0_gnt), 32'd1);
        drive(0, 1'b0, MNONE, '0, '0);
        step(4);

        // Read on the last owned cycle, then the other side writes
        c1 = rv1_cnt;
        drive(0, 1'b1, MNONE, '0, '0);
        step(1);
        drive(1, 1'b1, MWRITE, 9'h010, 16'h1234);
        drive(0, 1'b0, MREAD, 9'h007, '0);
        step(1);
        chk("xsw_m1_gnt", 32'(m1_gnt), 32'd1);
        drive(0, 1'b0, MNONE, '0, '0);
        step(1);
        chk("xsw_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("xsw_m0_rdata", 32'(m0_rdata), 32'h0000001C);
        drive(1, 1'b0, MNONE, '0, '0);
        step(3);
        chk("xsw_ram_10", 32'(ram[16]), 32'h00001234);
        chk("xsw_m1_no_rvalid", 32'(rv1_cnt - c1), 32'd0);

        // Reset between read issue and return
        drive(0, 1'b1, MNONE, '0, '0);
        step(1);
        drive(0, 1'b1, MREAD, 9'h005, '0);
        step(1);
        c0 = rv0_cnt;
        rst = 1'b1;
        drive(0, 1'b0, MNONE, '0, '0);
        step(1);
        rst = 1'b0;
        chk("rstrd_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rstrd_gnt", 32'(m0_gnt), 32'd0);
        chk("rstrd_mem_cmd", 32'(mem_cmd), 32'(MNONE));
        chk("rstrd_rdata", 32'(m0_rdata), 32'd0);
        step(4);
        chk("rstrd_no_pulse", 32'(rv0_cnt - c0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
